// File: rtl/dac_serial_monitor_pkg.sv
// Shared definitions for the DAC serial bus monitor: FSM encodings,
// synchronizer reset levels and default widths.
package dac_serial_monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } monState;

  // Idle levels of the DAC bus, so synchronizers come out of reset quiet
  localparam logic SCLK_RESET_LEVEL = 1'b0;
  localparam logic DIN_RESET_LEVEL  = 1'b0;
  localparam logic CS_RESET_LEVEL   = 1'b1;

  localparam int DEFAULT_WORD_BITS = 8;
  localparam int DEFAULT_CNT_BITS  = 16;

endpackage

// File: rtl/dac_serial_monitor_sync_edge.sv
// Two-flop synchronizer followed by a delay flop for edge detection on one
// asynchronous input.
module bioee_sync_edge
  import dac_serial_monitor_pkg::*;
#(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic asyncIn,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1, s2, s3;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= RESET_VAL;
      s2 <= RESET_VAL;
      s3 <= RESET_VAL;
    end else begin
      s1 <= asyncIn;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign level = s2;
  assign rise  = s2 & ~s3;
  assign fall  = ~s2 & s3;

endmodule

// File: rtl/dac_serial_monitor.sv
// Oversampling receiver for the 3-wire DAC bus: deserializes each cs-framed
// word, pulses valid or error, and keeps saturating frame/error counters.
module dac_serial_monitor
  import dac_serial_monitor_pkg::*;
#(
  parameter int WORD_BITS = DEFAULT_WORD_BITS,
  parameter int CNT_BITS  = DEFAULT_CNT_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 dac_sclk,
  input  logic                 dac_din,
  input  logic                 dac_cs,
  output logic [WORD_BITS-1:0] dout,
  output logic                 dout_valid,
  output logic                 frame_error,
  output logic                 busy,
  output logic [CNT_BITS-1:0]  frame_count,
  output logic [CNT_BITS-1:0]  error_count
);

  localparam int BCW = $clog2(WORD_BITS + 2);
  localparam logic [BCW-1:0] BIT_MAX  = BCW'(WORD_BITS + 1);
  localparam logic [BCW-1:0] BIT_GOOD = BCW'(WORD_BITS);
  localparam logic [CNT_BITS-1:0] CNT_MAX = {CNT_BITS{1'b1}};

  logic sclkLevel, sclkRise, sclkFall;
  logic dinLevel, dinRise, dinFall;
  logic csLevel, csRise, csFall;
  logic unusedSync;

  bioee_sync_edge #(.RESET_VAL(SCLK_RESET_LEVEL)) syncSclk (
    .clk(clk), .rst(rst), .asyncIn(dac_sclk),
    .level(sclkLevel), .rise(sclkRise), .fall(sclkFall)
  );

  bioee_sync_edge #(.RESET_VAL(DIN_RESET_LEVEL)) syncDin (
    .clk(clk), .rst(rst), .asyncIn(dac_din),
    .level(dinLevel), .rise(dinRise), .fall(dinFall)
  );

  bioee_sync_edge #(.RESET_VAL(CS_RESET_LEVEL)) syncCs (
    .clk(clk), .rst(rst), .asyncIn(dac_cs),
    .level(csLevel), .rise(csRise), .fall(csFall)
  );

  assign unusedSync = ^{sclkLevel, sclkFall, dinRise, dinFall, csLevel};

  monState state, nextState;
  logic [1:0] flushCnt;
  logic flushed;
  logic startFrame;
  logic [WORD_BITS-1:0] shreg;
  logic [BCW-1:0] bitCnt;

  // The cs synchronizer resets high, so a bus already held low would look
  // like a cs fall; ignore edges until the pipeline holds real pin samples.
  assign flushed = (flushCnt == 2'd3);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      flushCnt <= 2'd0;
    end else begin
      state <= nextState;
      if (!flushed) flushCnt <= flushCnt + 2'd1;
    end
  end

  always_comb begin
    nextState  = state;
    busy       = 1'b0;
    startFrame = 1'b0;
    case (state)
      ST_IDLE: begin
        if (csFall && en && flushed) begin
          startFrame = 1'b1;
          nextState  = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        busy = 1'b1;
        if (csRise) nextState = ST_DONE;
      end
      ST_DONE:  nextState = ST_IDLE;
      default:  nextState = ST_IDLE;
    endcase
  end

  // A bit arriving in the same cycle as cs rise is shifted before DONE judges it
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg       <= '0;
      bitCnt      <= '0;
      dout        <= '0;
      dout_valid  <= 1'b0;
      frame_error <= 1'b0;
      frame_count <= '0;
      error_count <= '0;
    end else begin
      dout_valid  <= 1'b0;
      frame_error <= 1'b0;
      if (startFrame) begin
        shreg  <= '0;
        bitCnt <= '0;
      end else if (state == ST_SHIFT && sclkRise) begin
        shreg <= {shreg[WORD_BITS-2:0], dinLevel};
        if (bitCnt != BIT_MAX) bitCnt <= bitCnt + BCW'(1);
      end else if (state == ST_DONE) begin
        if (bitCnt == BIT_GOOD) begin
          dout       <= shreg;
          dout_valid <= 1'b1;
          if (frame_count != CNT_MAX) frame_count <= frame_count + CNT_BITS'(1);
        end else begin
          frame_error <= 1'b1;
          if (error_count != CNT_MAX) error_count <= error_count + CNT_BITS'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_dac_serial_monitor.sv
// Self-checking bench for dac_serial_monitor: drives 3-wire DAC frames and
// compares pulses, data and counters with a frame-level reference model.
module tb_dac_serial_monitor;

  localparam int WB  = 8;
  localparam int CB  = 16;
  localparam int CBS = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rstSat = 1'b1;
  logic en = 1'b1;
  logic dac_sclk = 1'b0;
  logic dac_din = 1'b0;
  logic dac_cs = 1'b1;

  logic [WB-1:0]  dout, doutSat;
  logic           dout_valid, frame_error, busy;
  logic           validSat, errorSat, busySat;
  logic [CB-1:0]  frame_count, error_count;
  logic [CBS-1:0] frameCountSat, errorCountSat;

  always #5 clk = ~clk;

  dac_serial_monitor #(.WORD_BITS(WB), .CNT_BITS(CB)) dut (
    .clk(clk), .rst(rst), .en(en),
    .dac_sclk(dac_sclk), .dac_din(dac_din), .dac_cs(dac_cs),
    .dout(dout), .dout_valid(dout_valid), .frame_error(frame_error),
    .busy(busy), .frame_count(frame_count), .error_count(error_count)
  );

  dac_serial_monitor #(.WORD_BITS(WB), .CNT_BITS(CBS)) dutSat (
    .clk(clk), .rst(rstSat), .en(en),
    .dac_sclk(dac_sclk), .dac_din(dac_din), .dac_cs(dac_cs),
    .dout(doutSat), .dout_valid(validSat), .frame_error(errorSat),
    .busy(busySat), .frame_count(frameCountSat), .error_count(errorCountSat)
  );

  int total = 0;
  int bad = 0;

  int validSeen = 0;
  int errSeen = 0;
  int satValidSeen = 0;
  logic busySeen = 1'b0;

  // Reference model state, advanced once per frame
  int expFrames = 0;
  int expErrs = 0;
  int expValid = 0;
  int expErrPulses = 0;
  int satFrames = 0;
  int satValid = 0;
  logic [WB-1:0] expDout = '0;

  always @(negedge clk) begin
    if (dout_valid) validSeen++;
    if (frame_error) errSeen++;
    if (validSat) satValidSeen++;
    if (busy) busySeen = 1'b1;
  end

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    expFrames = 0;
    expErrs = 0;
    expDout = '0;
    repeat (5) @(negedge clk);
  endtask

  // Sends nBits of bits MSB first at 1 MHz sclk; latency is clk cycles from
  // cs rise to the first valid/error pulse, or -1 if none within 10 cycles.
  task automatic sendFrame(input logic [15:0] bits, input int nBits,
                           input logic enStart, input int enDropAt,
                           output int latency);
    en = enStart;
    dac_cs = 1'b0;
    #500;
    for (int i = nBits - 1; i >= 0; i--) begin
      if (nBits - 1 - i == enDropAt) en = 1'b0;
      dac_din = bits[i];
      #500 dac_sclk = 1'b1;
      #500 dac_sclk = 1'b0;
    end
    #500 dac_cs = 1'b1;
    latency = -1;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk);
      #1;
      if ((dout_valid || frame_error) && latency < 0) latency = n;
    end
    @(negedge clk);
    #1000;
    en = 1'b1;
    if (enStart) begin
      if (nBits == WB) begin
        expDout = bits[WB-1:0];
        if (expFrames < 65535) expFrames++;
        expValid++;
        if (!rstSat) begin
          if (satFrames < 3) satFrames++;
          satValid++;
        end
      end else begin
        if (expErrs < 65535) expErrs++;
        expErrPulses++;
      end
    end
  endtask

  task automatic test_reset();
    doReset();
    total += 6;
    if (dout !== 8'h00) begin bad++; $display("[TB] FAIL reset_dout got=%h want=00", dout); end
    if (dout_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%b want=0", dout_valid); end
    if (frame_error !== 1'b0) begin bad++; $display("[TB] FAIL reset_error got=%b want=0", frame_error); end
    if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
    if (frame_count !== 16'd0) begin bad++; $display("[TB] FAIL reset_fcnt got=%0d want=0", frame_count); end
    if (error_count !== 16'd0) begin bad++; $display("[TB] FAIL reset_ecnt got=%0d want=0", error_count); end
  endtask

  task automatic test_single_frame();
    int lat;
    busySeen = 1'b0;
    sendFrame(16'h00A5, 8, 1'b1, -1, lat);
    total += 7;
    if (lat !== 4) begin bad++; $display("[TB] FAIL single_latency got=%0d want=4", lat); end
    if (dout !== expDout) begin bad++; $display("[TB] FAIL single_dout got=%h want=%h", dout, expDout); end
    if (validSeen !== expValid) begin bad++; $display("[TB] FAIL single_valid_pulses got=%0d want=%0d", validSeen, expValid); end
    if (errSeen !== expErrPulses) begin bad++; $display("[TB] FAIL single_error_pulses got=%0d want=%0d", errSeen, expErrPulses); end
    if (frame_count !== 16'(expFrames)) begin bad++; $display("[TB] FAIL single_fcnt got=%0d want=%0d", frame_count, expFrames); end
    if (busySeen !== 1'b1) begin bad++; $display("[TB] FAIL single_busy_seen got=%b want=1", busySeen); end
    if (busy !== 1'b0) begin bad++; $display("[TB] FAIL single_busy_after got=%b want=0", busy); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] words [3] = '{8'h00, 8'hFF, 8'h3C};
    int lat;
    doReset();
    for (int i = 0; i < 3; i++) begin
      sendFrame({8'h00, words[i]}, 8, 1'b1, -1, lat);
      total += 3;
      if (lat !== 4) begin bad++; $display("[TB] FAIL b2b_latency[%0d] got=%0d want=4", i, lat); end
      if (dout !== expDout) begin bad++; $display("[TB] FAIL b2b_dout[%0d] got=%h want=%h", i, dout, expDout); end
      if (validSeen !== expValid) begin bad++; $display("[TB] FAIL b2b_valid_pulses[%0d] got=%0d want=%0d", i, validSeen, expValid); end
    end
    total += 2;
    if (frame_count !== 16'(expFrames)) begin bad++; $display("[TB] FAIL b2b_fcnt got=%0d want=%0d", frame_count, expFrames); end
    if (errSeen !== expErrPulses) begin bad++; $display("[TB] FAIL b2b_error_pulses got=%0d want=%0d", errSeen, expErrPulses); end
  endtask

  task automatic test_bad_length();
    int lat7, lat9;
    sendFrame(16'h0055, 7, 1'b1, -1, lat7);
    sendFrame(16'h01AB, 9, 1'b1, -1, lat9);
    total += 6;
    if (lat7 !== 4) begin bad++; $display("[TB] FAIL short_latency got=%0d want=4", lat7); end
    if (lat9 !== 4) begin bad++; $display("[TB] FAIL long_latency got=%0d want=4", lat9); end
    if (errSeen !== expErrPulses) begin bad++; $display("[TB] FAIL badlen_error_pulses got=%0d want=%0d", errSeen, expErrPulses); end
    if (validSeen !== expValid) begin bad++; $display("[TB] FAIL badlen_valid_pulses got=%0d want=%0d", validSeen, expValid); end
    if (error_count !== 16'(expErrs)) begin bad++; $display("[TB] FAIL badlen_ecnt got=%0d want=%0d", error_count, expErrs); end
    if (dout !== expDout) begin bad++; $display("[TB] FAIL badlen_dout got=%h want=%h", dout, expDout); end
  endtask

  task automatic test_enable();
    int latOff, latDrop;
    sendFrame(16'h005A, 8, 1'b0, -1, latOff);
    total += 4;
    if (latOff !== -1) begin bad++; $display("[TB] FAIL en_off_pulse got=%0d want=-1", latOff); end
    if (frame_count !== 16'(expFrames)) begin bad++; $display("[TB] FAIL en_off_fcnt got=%0d want=%0d", frame_count, expFrames); end
    if (error_count !== 16'(expErrs)) begin bad++; $display("[TB] FAIL en_off_ecnt got=%0d want=%0d", error_count, expErrs); end
    if (dout !== expDout) begin bad++; $display("[TB] FAIL en_off_dout got=%h want=%h", dout, expDout); end
    sendFrame(16'h00C3, 8, 1'b1, 3, latDrop);
    total += 3;
    if (latDrop !== 4) begin bad++; $display("[TB] FAIL en_drop_latency got=%0d want=4", latDrop); end
    if (dout !== expDout) begin bad++; $display("[TB] FAIL en_drop_dout got=%h want=%h", dout, expDout); end
    if (frame_count !== 16'(expFrames)) begin bad++; $display("[TB] FAIL en_drop_fcnt got=%0d want=%0d", frame_count, expFrames); end
  endtask

  task automatic test_reset_mid_frame();
    int lat;
    int validBefore, errBefore;
    logic [7:0] partial = 8'hF0;
    validBefore = validSeen;
    errBefore = errSeen;
    dac_cs = 1'b0;
    #500;
    for (int i = 7; i >= 4; i--) begin
      dac_din = partial[i];
      #500 dac_sclk = 1'b1;
      #500 dac_sclk = 1'b0;
    end
    rst = 1'b1;
    #30 rst = 1'b0;
    expFrames = 0;
    expErrs = 0;
    expDout = '0;
    for (int i = 3; i >= 0; i--) begin
      dac_din = partial[i];
      #500 dac_sclk = 1'b1;
      #500 dac_sclk = 1'b0;
    end
    #500 dac_cs = 1'b1;
    #1500;
    total += 4;
    if (validSeen !== validBefore) begin bad++; $display("[TB] FAIL abort_valid_pulses got=%0d want=%0d", validSeen, validBefore); end
    if (errSeen !== errBefore) begin bad++; $display("[TB] FAIL abort_error_pulses got=%0d want=%0d", errSeen, errBefore); end
    if (frame_count !== 16'd0) begin bad++; $display("[TB] FAIL abort_fcnt got=%0d want=0", frame_count); end
    if (error_count !== 16'd0) begin bad++; $display("[TB] FAIL abort_ecnt got=%0d want=0", error_count); end
    sendFrame(16'h0081, 8, 1'b1, -1, lat);
    total += 3;
    if (lat !== 4) begin bad++; $display("[TB] FAIL after_abort_latency got=%0d want=4", lat); end
    if (dout !== expDout) begin bad++; $display("[TB] FAIL after_abort_dout got=%h want=%h", dout, expDout); end
    if (frame_count !== 16'(expFrames)) begin bad++; $display("[TB] FAIL after_abort_fcnt got=%0d want=%0d", frame_count, expFrames); end
  endtask

  task automatic test_random();
    int lat, nb, expLat;
    logic [15:0] w;
    logic e;
    for (int k = 0; k < 8; k++) begin
      nb = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 10)) : WB;
      w = 16'($urandom);
      e = ($urandom_range(0, 4) != 0);
      expLat = e ? 4 : -1;
      sendFrame(w, nb, e, -1, lat);
      total += 5;
      if (lat !== expLat) begin bad++; $display("[TB] FAIL rand_latency[%0d] got=%0d want=%0d", k, lat, expLat); end
      if (dout !== expDout) begin bad++; $display("[TB] FAIL rand_dout[%0d] got=%h want=%h", k, dout, expDout); end
      if (frame_count !== 16'(expFrames)) begin bad++; $display("[TB] FAIL rand_fcnt[%0d] got=%0d want=%0d", k, frame_count, expFrames); end
      if (error_count !== 16'(expErrs)) begin bad++; $display("[TB] FAIL rand_ecnt[%0d] got=%0d want=%0d", k, error_count, expErrs); end
      if (errSeen !== expErrPulses) begin bad++; $display("[TB] FAIL rand_error_pulses[%0d] got=%0d want=%0d", k, errSeen, expErrPulses); end
    end
  endtask

  task automatic test_saturation();
    int lat;
    logic [15:0] w;
    @(negedge clk);
    rstSat = 1'b0;
    repeat (5) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      w = 16'($urandom_range(0, 255));
      sendFrame(w, 8, 1'b1, -1, lat);
      total += 3;
      if (frameCountSat !== 2'(satFrames)) begin bad++; $display("[TB] FAIL sat_fcnt[%0d] got=%0d want=%0d", k, frameCountSat, satFrames); end
      if (satValidSeen !== satValid) begin bad++; $display("[TB] FAIL sat_valid_pulses[%0d] got=%0d want=%0d", k, satValidSeen, satValid); end
      if (doutSat !== expDout) begin bad++; $display("[TB] FAIL sat_dout[%0d] got=%h want=%h", k, doutSat, expDout); end
    end
    total += 1;
    if (errorCountSat !== 2'd0) begin bad++; $display("[TB] FAIL sat_ecnt got=%0d want=0", errorCountSat); end
  endtask

  initial begin
    $display("[TB] starting dac_serial_monitor bench");
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_bad_length();
    test_enable();
    test_reset_mid_frame();
    test_random();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
